// File: rtl/multi_debouncer.sv
// multi_debouncer: N-channel switch/encoder debouncer.
// Each channel passes through a two-flop synchroniser. All channels are then
// sampled on a shared divided tick. A channel's output changes only after
// STABLE_COUNT consecutive samples disagree with the current output.
// rise/fall/bounce/changed are registered one-cycle strobes. They are high in
// the same cycle that dout takes its new value.
module multi_debouncer #(
  parameter int   CHANNELS     = 2,
  parameter int   SAMPLE_DIV   = 100,
  parameter int   STABLE_COUNT = 4,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] bounce,
  output logic                changed
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CNT_W = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [DIV_W-1:0]    div;
  logic                tick;

  logic [CNT_W-1:0]    cnt      [CHANNELS];
  logic [CNT_W-1:0]    cnt_nxt  [CHANNELS];
  logic [CHANNELS-1:0] dout_nxt;
  logic [CHANNELS-1:0] rise_nxt;
  logic [CHANNELS-1:0] fall_nxt;
  logic [CHANNELS-1:0] bounce_nxt;

  // The synchroniser runs every cycle, whatever the state of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= {CHANNELS{RESET_LEVEL}};
      sync2 <= {CHANNELS{RESET_LEVEL}};
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // The sample tick fires on the last count of the divider. en low holds it.
  assign tick = en && (div == DIV_LAST);

  // The divider counts 0..SAMPLE_DIV-1 while enabled, then wraps to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (en) begin
      if (div == DIV_LAST) div <= '0;
      else                 div <= div + DIV_W'(1);
    end
  end

  // Per-channel decision: agree, count toward a change, or commit the change.
  always_comb begin
    dout_nxt   = dout;
    rise_nxt   = '0;
    fall_nxt   = '0;
    bounce_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_nxt[i] = cnt[i];
      if (tick) begin
        if (sync2[i] == dout[i]) begin
          // Input is back at the settled level. A partly built count was a bounce.
          cnt_nxt[i]    = '0;
          bounce_nxt[i] = (cnt[i] != '0);
        end else if (cnt[i] == CNT_LAST) begin
          dout_nxt[i] = sync2[i];
          cnt_nxt[i]  = '0;
          rise_nxt[i] = sync2[i];
          fall_nxt[i] = ~sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Register the counters, the levels and the strobes together, so that the
  // strobes line up with the dout transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
      dout    <= {CHANNELS{RESET_LEVEL}};
      rise    <= '0;
      fall    <= '0;
      bounce  <= '0;
      changed <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= cnt_nxt[i];
      dout    <= dout_nxt;
      rise    <= rise_nxt;
      fall    <= fall_nxt;
      bounce  <= bounce_nxt;
      changed <= |(rise_nxt | fall_nxt);
    end
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer.
// dut_a runs with SAMPLE_DIV=4 and STABLE_COUNT=3, so a change needs between
// 10 and 13 edges. dut_b runs with SAMPLE_DIV=1 and STABLE_COUNT=1, so dout
// follows din on the third edge after din changes.
module tb_multi_debouncer;

  logic       clk;
  logic       rst;
  logic       a_en;
  logic [1:0] a_din;
  logic [1:0] a_dout;
  logic [1:0] a_rise;
  logic [1:0] a_fall;
  logic [1:0] a_bounce;
  logic       a_changed;
  logic       b_en;
  logic [0:0] b_din;
  logic [0:0] b_dout;
  logic [0:0] b_rise;
  logic [0:0] b_fall;
  logic [0:0] b_bounce;
  logic       b_changed;

  int checks = 0;
  int errors = 0;
  int b_bounce_seen = 0;

  multi_debouncer #(
    .CHANNELS(2), .SAMPLE_DIV(4), .STABLE_COUNT(3), .RESET_LEVEL(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .en(a_en), .din(a_din), .dout(a_dout),
    .rise(a_rise), .fall(a_fall), .bounce(a_bounce), .changed(a_changed)
  );

  multi_debouncer #(
    .CHANNELS(1), .SAMPLE_DIV(1), .STABLE_COUNT(1), .RESET_LEVEL(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .en(b_en), .din(b_din), .dout(b_dout),
    .rise(b_rise), .fall(b_fall), .bounce(b_bounce), .changed(b_changed)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // dut_b must never report a bounce.
  always @(negedge clk) if (b_bounce !== 1'b0) b_bounce_seen++;

  // Wait a bounded number of cycles for dut_a to settle at a given level.
  task automatic wait_a_dout(input logic [1:0] target, input string name);
    int k;
    k = 0;
    while (a_dout !== target && k < 60) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (a_dout !== target) begin
      errors++;
      $display("FAIL %s timeout: dout=%b required %b", name, a_dout, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; a_en = 1'b1; b_en = 1'b1; a_din = 2'b00; b_din = 1'b0;
    #1;
    checks++;
    if (a_dout !== 2'b00 || b_dout !== 1'b0) begin
      errors++;
      $display("FAIL reset_dout: a=%b b=%b required 00/0", a_dout, b_dout);
    end
    checks++;
    if ({a_rise, a_fall, a_bounce, a_changed} !== 7'd0 ||
        {b_rise, b_fall, b_bounce, b_changed} !== 4'd0) begin
      errors++;
      $display("FAIL reset_strobes: a=%b b=%b required 0",
               {a_rise, a_fall, a_bounce, a_changed}, {b_rise, b_fall, b_bounce, b_changed});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_bounce();
    int bounce_cycles, rise_cycles, high_cycles, other;
    bounce_cycles = 0; rise_cycles = 0; high_cycles = 0; other = 0;
    @(negedge clk);
    a_din = 2'b01;
    for (int k = 0; k < 46; k++) begin
      @(negedge clk);
      if (k == 5) a_din = 2'b00;
      if (a_bounce[0]) bounce_cycles++;
      if (a_rise[0]) rise_cycles++;
      if (a_dout[0]) high_cycles++;
      if (a_bounce[1] || a_changed || a_fall !== 2'b00) other++;
    end
    checks++;
    if (bounce_cycles != 1) begin
      errors++;
      $display("FAIL bounce_pulse: bounce[0] high %0d cycles, required 1", bounce_cycles);
    end
    checks++;
    if (rise_cycles != 0 || high_cycles != 0) begin
      errors++;
      $display("FAIL bounce_no_rise: rise cycles %0d dout high cycles %0d, required 0/0",
               rise_cycles, high_cycles);
    end
    checks++;
    if (other != 0) begin
      errors++;
      $display("FAIL bounce_other: stray strobe cycles %0d, required 0", other);
    end
  endtask

  task automatic test_clean_edge();
    int first_k, rise_cycles, fall_cycles;
    first_k = -1; rise_cycles = 0; fall_cycles = 0;
    a_din = 2'b01;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (a_rise[0]) rise_cycles++;
      if (a_fall !== 2'b00) fall_cycles++;
      if (first_k < 0 && a_dout[0]) begin
        first_k = k;
        checks++;
        if (a_rise !== 2'b01 || a_fall !== 2'b00 || a_changed !== 1'b1) begin
          errors++;
          $display("FAIL clean_strobes: rise=%b fall=%b changed=%b required 01/00/1",
                   a_rise, a_fall, a_changed);
        end
      end
    end
    checks++;
    if (first_k - 1 < 10 || first_k - 1 > 13) begin
      errors++;
      $display("FAIL clean_latency: %0d edges after capture, required 10..13", first_k - 1);
    end
    checks++;
    if (rise_cycles != 1 || fall_cycles != 0) begin
      errors++;
      $display("FAIL clean_pulse: rise cycles %0d fall cycles %0d, required 1/0",
               rise_cycles, fall_cycles);
    end
    checks++;
    if (a_dout !== 2'b01 || a_changed !== 1'b0) begin
      errors++;
      $display("FAIL clean_final: dout=%b changed=%b required 01/0", a_dout, a_changed);
    end
  endtask

  task automatic test_simultaneous();
    int changed_cycles;
    logic seen;
    a_din = 2'b00;
    wait_a_dout(2'b00, "simul_prep");
    @(negedge clk);
    a_din = 2'b11;
    changed_cycles = 0; seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (a_changed) changed_cycles++;
      if (!seen && a_dout !== 2'b00) begin
        seen = 1'b1;
        checks++;
        if (a_dout !== 2'b11 || a_rise !== 2'b11 || a_fall !== 2'b00) begin
          errors++;
          $display("FAIL simul_rise: dout=%b rise=%b fall=%b required 11/11/00",
                   a_dout, a_rise, a_fall);
        end
      end
    end
    checks++;
    if (changed_cycles != 1 || a_dout !== 2'b11) begin
      errors++;
      $display("FAIL simul_changed: changed cycles %0d dout=%b required 1/11",
               changed_cycles, a_dout);
    end
    a_din = 2'b01;
    changed_cycles = 0; seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (a_changed) changed_cycles++;
      if (!seen && a_dout !== 2'b11) begin
        seen = 1'b1;
        checks++;
        if (a_dout !== 2'b01 || a_fall !== 2'b10 || a_rise !== 2'b00 || a_changed !== 1'b1) begin
          errors++;
          $display("FAIL simul_fall: dout=%b fall=%b rise=%b changed=%b required 01/10/00/1",
                   a_dout, a_fall, a_rise, a_changed);
        end
      end
    end
    checks++;
    if (changed_cycles != 1 || a_dout !== 2'b01) begin
      errors++;
      $display("FAIL simul_fall_once: changed cycles %0d dout=%b required 1/01",
               changed_cycles, a_dout);
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    a_din = 2'b11;
    wait_a_dout(2'b11, "reset_mid_prep");
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    a_din = 2'b00;
    #1;
    checks++;
    if (a_dout !== 2'b00 || {a_rise, a_fall, a_bounce, a_changed} !== 7'd0) begin
      errors++;
      $display("FAIL reset_mid: dout=%b strobes=%b required 00/0",
               a_dout, {a_rise, a_fall, a_bounce, a_changed});
    end
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a_dout !== 2'b00 || {a_rise, a_fall, a_bounce, a_changed} !== 7'd0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL reset_release: %0d cycles with activity, required 0", stray);
    end
  endtask

  task automatic test_enable_freeze();
    int moved;
    @(negedge clk);
    rst = 1'b1;
    a_din = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    a_din = 2'b01;
    // 4 edges: the synchroniser fills and the first tick counts the new level.
    repeat (4) @(negedge clk);
    checks++;
    if (a_dout !== 2'b00) begin
      errors++;
      $display("FAIL freeze_first_tick: dout=%b required 00", a_dout);
    end
    a_en = 1'b0;
    moved = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (a_dout !== 2'b00 || a_changed !== 1'b0) moved++;
    end
    checks++;
    if (moved != 0) begin
      errors++;
      $display("FAIL freeze_hold: %0d cycles changed while frozen, required 0", moved);
    end
    a_en = 1'b1;
    moved = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (a_dout !== 2'b00) moved++;
    end
    checks++;
    if (moved != 0) begin
      errors++;
      $display("FAIL freeze_early: dout changed %0d cycles early, required 0", moved);
    end
    @(negedge clk);
    checks++;
    if (a_dout !== 2'b01 || a_rise !== 2'b01) begin
      errors++;
      $display("FAIL freeze_resume: dout=%b rise=%b required 01/01", a_dout, a_rise);
    end
  endtask

  task automatic test_degenerate();
    logic [0:0] vals [4];
    logic [0:0] old_v;
    logic [0:0] pulse_exp [5];
    vals[0] = 1'b1; vals[1] = 1'b0; vals[2] = 1'b1; vals[3] = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      old_v = b_dout;
      b_din = vals[s];
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        checks++;
        if (k < 3 && b_dout !== old_v) begin
          errors++;
          $display("FAIL degen_step%0d_e%0d: dout=%b required %b", s, k, b_dout, old_v);
        end else if (k == 3 && b_dout !== vals[s]) begin
          errors++;
          $display("FAIL degen_step%0d_e3: dout=%b required %b", s, b_dout, vals[s]);
        end
      end
      @(negedge clk);
    end
    // A one-cycle input pulse is reproduced as a one-cycle output pulse.
    pulse_exp[0] = 1'b0; pulse_exp[1] = 1'b0; pulse_exp[2] = 1'b1;
    pulse_exp[3] = 1'b0; pulse_exp[4] = 1'b0;
    b_din = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) b_din = 1'b0;
      checks++;
      if (b_dout !== pulse_exp[k] || b_rise !== pulse_exp[k]) begin
        errors++;
        $display("FAIL degen_pulse_e%0d: dout=%b rise=%b required %b", k + 1, b_dout, b_rise,
                 pulse_exp[k]);
      end
    end
    checks++;
    if (b_bounce_seen != 0) begin
      errors++;
      $display("FAIL degen_bounce: bounce seen %0d cycles, required 0", b_bounce_seen);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_edge();
    test_simultaneous();
    test_reset_mid();
    test_enable_freeze();
    test_degenerate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
